// File: rtl/seq_array_multiplier.sv
// rtl/seq_array_multiplier.sv - shift-and-add multiplier, one multiplier bit per cycle
// Optional MULT_SIGNED_EN adds port tc for two's complement operands.
module seq_array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     result;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [CW-1:0]     cnt;

`ifdef MULT_SIGNED_EN
  logic a_neg, b_neg, neg_r;

  // Signed mode runs on magnitudes; the sign is restored when product is loaded.
  assign a_neg  = tc & a[WIDTH-1];
  assign b_neg  = tc & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign result = neg_r ? -acc_sum : acc_sum;
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_sum;
`endif

  assign acc_sum = acc + (mplier[0] ? mcand : {PW{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // product is written on the edge entering DONE so it is visible alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
`ifdef MULT_SIGNED_EN
            neg_r  <= a_neg ^ b_neg;
`endif
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) product <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// tb/tb_seq_array_multiplier.sv - directed and scoreboard checks for seq_array_multiplier
module tb_seq_array_multiplier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       tc_v = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_prod = '0;

  always #5 clk = ~clk;

  seq_array_multiplier #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef MULT_SIGNED_EN
    .tc      (tc_v),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input logic t);
    logic signed [7:0] sx, sy;
    if (t) begin
      sx = {{4{x[3]}}, x};
      sy = {{4{y[3]}}, y};
      return sx * sy;
    end
    return {4'b0, x} * {4'b0, y};
  endfunction

  // Scoreboard: every done pulse retires the oldest expected product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("sb_pending", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("sb_product", 16'(product), 16'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_in, input logic ttc);
    logic [7:0] e;
    e = model(ta, tb_in, ttc);
    a = ta; b = tb_in; tc_v = ttc; start = 1'b1;
    exp_q.push_back(e);
    step();
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    for (int k = 1; k <= 4; k++) begin
      check("run_busy", 16'(busy), 16'd1);
      check("run_done", 16'(done), 16'd0);
      check("run_hold", 16'(product), 16'(last_prod));
      step();
    end
    check("done_busy", 16'(busy), 16'd0);
    check("done_pulse", 16'(done), 16'd1);
    check("done_product", 16'(product), 16'(e));
    last_prod = e;
    step();
    check("after_done", 16'(done), 16'd0);
    check("after_hold", 16'(product), 16'(last_prod));
  endtask

  initial begin
    #1;
    step();
    step();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_product", 16'(product), 16'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 16'(busy), 16'd0);

    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0, 4'd9, 1'b0);
    run_op(4'd9, 4'd0, 1'b0);

    // start held high: one result every six cycles
    a = 4'd3; b = 4'd5; start = 1'b1;
    repeat (3) exp_q.push_back(8'h0F);
    for (int c = 1; c <= 17; c++) begin
      step();
      check("held_done", 16'(done), 16'(c == 5 || c == 11 || c == 17));
      if (c == 5 || c == 11 || c == 17) check("held_product", 16'(product), 16'h0F);
    end
    start = 1'b0;
    last_prod = 8'h0F;
    step();
    step();

    // reset aborts an in-flight operation
    a = 4'd7; b = 4'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_prod = '0;
    for (int c = 3; c <= 8; c++) begin
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_done", 16'(done), 16'd0);
      check("abort_product", 16'(product), 16'd0);
      step();
    end
    run_op(4'd2, 4'd3, 1'b0);

    // start and operand changes during RUN are ignored
    a = 4'd5; b = 4'd5; start = 1'b1;
    exp_q.push_back(8'h19);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 4) begin
        a = 4'd15; b = 4'd15;
      end else begin
        start = 1'b0;
      end
      check("ign_done", 16'(done), 16'(c == 5));
      if (c == 5) check("ign_product", 16'(product), 16'h19);
    end
    last_prod = 8'h19;

    // start held across reset release is taken on the first free edge
    rst = 1'b1; start = 1'b1;
    step();
    check("rel_busy", 16'(busy), 16'd0);
    check("rel_product", 16'(product), 16'd0);
    last_prod = '0;
    rst = 1'b0;
    run_op(4'd6, 4'd7, 1'b0);

    for (int i = 0; i < 6; i++) run_op(4'($urandom), 4'($urandom), 1'b0);

`ifdef MULT_SIGNED_EN
    run_op(4'h8, 4'h7, 1'b1);
    check("signed_neg", 16'(last_prod), 16'hC8);
    run_op(4'h8, 4'h8, 1'b1);
    run_op(4'h8, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) run_op(4'($urandom), 4'($urandom), 1'b1);
`endif

    step();
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_array_multiplier.md
SEQ_ARRAY_MULTIPLIER -- requirements
Module: seq_array_multiplier

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 a  input  WIDTH  multiplicand; captured on the accepted start edge.
REQ-007 b  input  WIDTH  multiplier; captured on the accepted start edge.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse marking a new valid product.
REQ-010 product  output  2*WIDTH  registered result; holds the last result until the next done.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE and no others.
REQ-012 IDLE with start=1 SHALL capture a, b, clear the accumulator, load the bit counter with 0, and go to RUN on the same edge.
REQ-013 IDLE with start=0 SHALL remain in IDLE.
REQ-014 RUN SHALL process one bit of b per cycle, LSB first: if the bit is 1, add (a << counter) to the 2*WIDTH-bit accumulator.
REQ-015 The accumulator SHALL never overflow, since the result of a WIDTH x WIDTH unsigned multiply fits in 2*WIDTH bits.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go to DONE; there is no early termination on zero operands.
REQ-017 DONE SHALL load product from the accumulator, assert done for exactly that cycle, and return to IDLE unconditionally.
REQ-018 Latency: with start high in cycle 0, busy SHALL be high in cycles 1..WIDTH, and done and the new product SHALL appear in cycle WIDTH+1.
REQ-019 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 Changes on a or b after capture SHALL NOT affect the running operation.
REQ-021 The next accepted start is possible no earlier than cycle WIDTH+2, giving a throughput of one result per WIDTH+2 cycles.
REQ-022 product SHALL change only in DONE or on reset.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE and clear busy, done, product, accumulator and counter to 0.
REQ-024 Reset SHALL take priority over start and over any in-flight operation.
REQ-025 An operation interrupted by reset SHALL be discarded, with no done pulse.
REQ-026 start held high across reset release SHALL be accepted on the first edge with rst=0.

Configuration
REQ-027 Macro MULT_SIGNED_EN defined: add port tc (input, 1), captured with the operands; tc=1 treats a and b as two's complement.
REQ-028 With MULT_SIGNED_EN defined, the signed operation SHALL take magnitudes, run the unsigned sequence, and negate the result in the DONE load when the operand signs differ.
REQ-029 With MULT_SIGNED_EN defined, latency SHALL be identical to the unsigned case.
REQ-030 With MULT_SIGNED_EN defined and tc=0, behaviour SHALL equal the macro-absent behaviour.
REQ-031 Macro MULT_SIGNED_EN not defined: port tc SHALL NOT exist and all operands SHALL be unsigned.

Verification (WIDTH=4)
REQ-032 a=15, b=15, start pulse in cycle 0 -> busy in cycles 1..4, done in cycle 5, product=0xE1 (225).
REQ-033 a=0, b=9 -> product=0x00 in cycle 5; a=9, b=0 -> product=0x00; previous product held until each done.
REQ-034 start=1 held continuously with a=3, b=5 -> done in cycles 5, 11, 17 (period 6), product=0x0F each time.
REQ-035 a=7, b=6 started, then rst=1 in cycle 2 -> no done; busy=0 and product=0 from cycle 3; new start a=2, b=3 -> product=0x06.
REQ-036 a=5, b=5 started; a=15, b=15 and start=1 applied in cycles 1..4 -> product=0x19, only one done.
REQ-037 With MULT_SIGNED_EN, tc=1: a=-8, b=7 -> product=0xC8 (-56); a=-8, b=-8 -> 0x40 (64); tc=0, a=8, b=7 -> 0x38.
